// File: rtl/kf76489_stereo_psg_pkg.sv
`default_nettype none
// ============================================================================
// kf76489_stereo_psg_pkg
// Shared types, constants and the attenuation-to-level table for the PSG.
// Rev 1.0
// ============================================================================
package kf76489_stereo_psg_pkg;

    typedef enum logic {
        REG_FREQ = 1'b0,
        REG_ATT  = 1'b1
    } reg_type_e;

    typedef enum logic [1:0] {
        CH_TONE1 = 2'd0,
        CH_TONE2 = 2'd1,
        CH_TONE3 = 2'd2,
        CH_NOISE = 2'd3
    } chan_e;

    localparam int unsigned NUM_TONES  = 3;
    localparam int unsigned NUM_CH     = 4;
    localparam int unsigned PAN_R_BASE = 0;
    localparam int unsigned PAN_L_BASE = 4;

    localparam logic [5:0] NOISE_RELOAD_16 = 6'd15;
    localparam logic [5:0] NOISE_RELOAD_32 = 6'd31;
    localparam logic [5:0] NOISE_RELOAD_64 = 6'd63;

    function automatic logic [5:0] noise_reload(input logic [1:0] rate);
        logic [5:0] r;
        case (rate)
            2'b00:   r = NOISE_RELOAD_16;
            2'b01:   r = NOISE_RELOAD_32;
            default: r = NOISE_RELOAD_64;
        endcase
        return r;
    endfunction

    // 2 dB steps on a 0..63 scale, rescaled to the requested level width.
    function automatic int unsigned vol_table(input logic [3:0] att, input int unsigned vol_w);
        int unsigned v;
        v = 0;
        case (att)
            4'h0: v = 63;
            4'h1: v = 50;
            4'h2: v = 40;
            4'h3: v = 32;
            4'h4: v = 25;
            4'h5: v = 20;
            4'h6: v = 16;
            4'h7: v = 12;
            4'h8: v = 10;
            4'h9: v = 8;
            4'hA: v = 6;
            4'hB: v = 5;
            4'hC: v = 4;
            4'hD: v = 3;
            4'hE: v = 2;
            default: v = 0;
        endcase
        return (v * ((32'd1 << vol_w) - 32'd1)) / 32'd63;
    endfunction

endpackage
`default_nettype wire

// File: rtl/kf76489_psg_tone_channel.sv
`default_nettype none
// ============================================================================
// kf76489_psg_tone_channel
// One square-tone voice: period, down-counter, toggle output, attenuation, level.
// Rev 1.0
// ============================================================================
module kf76489_psg_tone_channel
    import kf76489_stereo_psg_pkg::*;
#(
    parameter int unsigned VOL_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick_i,
    input  logic             per_lo_we_i,
    input  logic             per_hi_we_i,
    input  logic             att_we_i,
    input  logic [5:0]       data_i,
    output logic             tone_o,
    output logic [VOL_W-1:0] level_o
);

    logic [9:0]       period_q, period_d;
    logic [9:0]       cnt_q, cnt_d;
    logic             tone_q, tone_d;
    logic [3:0]       att_q, att_d;
    logic [VOL_W-1:0] lut [16];

    generate
        for (genvar k = 0; k < 16; k++) begin : g_lut
            assign lut[k] = VOL_W'(vol_table(4'(k), VOL_W));
        end
    endgenerate

    always_comb begin
        period_d = period_q;
        att_d    = att_q;
        cnt_d    = cnt_q;
        tone_d   = tone_q;
        if (per_lo_we_i) period_d[3:0] = data_i[3:0];
        if (per_hi_we_i) period_d[9:4] = data_i[5:0];
        if (att_we_i)    att_d         = data_i[3:0];
        // The reload uses the period in force before any same-cycle write.
        if (tick_i) begin
            if (cnt_q == 10'd0) begin
                if (period_q <= 10'd1) begin
                    cnt_d  = 10'd0;
                    tone_d = 1'b1;
                end else begin
                    cnt_d  = period_q - 10'd1;
                    tone_d = ~tone_q;
                end
            end else begin
                cnt_d = cnt_q - 10'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            period_q <= '0;
            cnt_q    <= '0;
            tone_q   <= 1'b1;
            att_q    <= 4'hF;
        end else begin
            period_q <= period_d;
            cnt_q    <= cnt_d;
            tone_q   <= tone_d;
            att_q    <= att_d;
        end
    end

    assign tone_o  = tone_q;
    assign level_o = tone_q ? lut[att_q] : '0;

endmodule
`default_nettype wire

// File: rtl/kf76489_stereo_psg.sv
`default_nettype none
// ============================================================================
// kf76489_stereo_psg
// SN76489-class PSG, 3 tones + noise, per-channel stereo pan, READY wait-state.
// Rev 1.0
// ============================================================================
module kf76489_stereo_psg
    import kf76489_stereo_psg_pkg::*;
#(
    parameter int unsigned       DIVIDER      = 16,
    parameter int unsigned       LFSR_W       = 16,
    parameter logic [LFSR_W-1:0] TAP_MASK     = LFSR_W'(16'h0009),
    parameter int unsigned       VOL_W        = 6,
    parameter int unsigned       READY_CYCLES = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clock_enable,
    input  logic             CE_N,
    input  logic             WE_N,
    input  logic             STEREO_WE_N,
    input  logic [7:0]       D_IN,
    output logic             READY,
    output logic [VOL_W+1:0] AOUT_L,
    output logic [VOL_W+1:0] AOUT_R,
    output logic [VOL_W+1:0] AOUT
);

    localparam int unsigned       DIV_W     = (DIVIDER > 2) ? $clog2(DIVIDER) : 1;
    localparam int unsigned       BUSY_W    = $clog2(READY_CYCLES + 1);
    localparam int unsigned       MIX_W     = VOL_W + 2;
    localparam logic [LFSR_W-1:0] LFSR_SEED = {1'b1, {(LFSR_W-1){1'b0}}};

    logic              sel_prev_q, sel_prev_d;
    logic              stereo_prev_q, stereo_prev_d;
    logic              ready_q, ready_d;
    logic [BUSY_W-1:0] busy_q, busy_d;
    chan_e             latch_ch_q, latch_ch_d;
    reg_type_e         latch_type_q, latch_type_d;
    logic [7:0]        pan_q, pan_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [2:0]        nctrl_q, nctrl_d;
    logic [3:0]        natt_q, natt_d;
    logic [5:0]        ncnt_q, ncnt_d;
    logic              nsq_q, nsq_d;
    logic              nsrc_prev_q, nsrc_prev_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [MIX_W-1:0]  mono_q, mono_d, left_q, left_d, right_q, right_d;

    logic              sel_n, accept, pan_we, tick;
    chan_e             tgt_ch;
    reg_type_e         tgt_type;
    logic [2:0]        tone;
    logic              unused_tones;
    logic [VOL_W-1:0]  level [NUM_CH];
    logic [VOL_W-1:0]  nlut [16];
    logic              nsrc, fb, nctrl_we, natt_we;

    assign sel_n    = CE_N | WE_N;
    assign accept   = ready_q & sel_prev_q & ~sel_n;
    assign pan_we   = stereo_prev_q & ~STEREO_WE_N;
    assign tick     = clock_enable && (div_q == DIV_W'(DIVIDER - 1));
    assign tgt_ch   = D_IN[7] ? chan_e'(D_IN[6:5]) : latch_ch_q;
    assign tgt_type = D_IN[7] ? reg_type_e'(D_IN[4]) : latch_type_q;

    generate
        for (genvar i = 0; i < NUM_TONES; i++) begin : g_tone
            logic sel_this;
            assign sel_this = accept && (tgt_ch == chan_e'(2'(i)));
            kf76489_psg_tone_channel #(
                .VOL_W(VOL_W)
            ) u_tone (
                .clock       (clock),
                .reset       (reset),
                .tick_i      (tick),
                .per_lo_we_i (sel_this && tgt_type == REG_FREQ && D_IN[7]),
                .per_hi_we_i (sel_this && tgt_type == REG_FREQ && !D_IN[7]),
                .att_we_i    (sel_this && tgt_type == REG_ATT),
                .data_i      (D_IN[5:0]),
                .tone_o      (tone[i]),
                .level_o     (level[i])
            );
        end
        for (genvar k = 0; k < 16; k++) begin : g_nlut
            assign nlut[k] = VOL_W'(vol_table(4'(k), VOL_W));
        end
    endgenerate

    assign unused_tones = ^tone[1:0];

    assign nctrl_we = accept && tgt_ch == CH_NOISE && tgt_type == REG_FREQ;
    assign natt_we  = accept && tgt_ch == CH_NOISE && tgt_type == REG_ATT;
    // Rate 11 borrows tone 3's toggle, regardless of tone 3's attenuation.
    assign nsrc     = (nctrl_q[1:0] == 2'b11) ? tone[2] : nsq_q;
    assign fb       = nctrl_q[2] ? ^(lfsr_q & TAP_MASK) : lfsr_q[0];
    assign level[3] = lfsr_q[0] ? nlut[natt_q] : '0;

    always_comb begin
        sel_prev_d    = sel_n;
        stereo_prev_d = STEREO_WE_N;
        ready_d       = ready_q;
        busy_d        = busy_q;
        latch_ch_d    = latch_ch_q;
        latch_type_d  = latch_type_q;
        pan_d         = pan_we ? D_IN : pan_q;
        div_d         = clock_enable ? div_q + DIV_W'(1) : div_q;
        if (accept) begin
            ready_d = 1'b0;
            busy_d  = BUSY_W'(READY_CYCLES);
        end else if (!ready_q && clock_enable) begin
            if (busy_q <= BUSY_W'(1)) begin
                ready_d = 1'b1;
                busy_d  = '0;
            end else begin
                busy_d = busy_q - BUSY_W'(1);
            end
        end
        if (accept && D_IN[7]) begin
            latch_ch_d   = tgt_ch;
            latch_type_d = tgt_type;
        end
    end

    always_comb begin
        nctrl_d     = nctrl_we ? D_IN[2:0] : nctrl_q;
        natt_d      = natt_we ? D_IN[3:0] : natt_q;
        ncnt_d      = ncnt_q;
        nsq_d       = nsq_q;
        nsrc_prev_d = nsrc;
        lfsr_d      = lfsr_q;
        if (tick) begin
            if (ncnt_q == 6'd0) begin
                ncnt_d = noise_reload(nctrl_q[1:0]);
                nsq_d  = ~nsq_q;
            end else begin
                ncnt_d = ncnt_q - 6'd1;
            end
        end
        if (nctrl_we) begin
            lfsr_d = LFSR_SEED;
        end else if (nsrc && !nsrc_prev_q) begin
            lfsr_d = {fb, lfsr_q[LFSR_W-1:1]};
        end
    end

    always_comb begin
        mono_d  = '0;
        left_d  = '0;
        right_d = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            mono_d = mono_d + MIX_W'(level[ch]);
            if (pan_q[PAN_R_BASE + ch]) right_d = right_d + MIX_W'(level[ch]);
            if (pan_q[PAN_L_BASE + ch]) left_d  = left_d + MIX_W'(level[ch]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sel_prev_q    <= 1'b1;
            stereo_prev_q <= 1'b1;
            ready_q       <= 1'b1;
            busy_q        <= '0;
            latch_ch_q    <= CH_TONE1;
            latch_type_q  <= REG_FREQ;
            pan_q         <= 8'hFF;
            div_q         <= '0;
            nctrl_q       <= '0;
            natt_q        <= 4'hF;
            ncnt_q        <= '0;
            nsq_q         <= 1'b0;
            nsrc_prev_q   <= 1'b1;
            lfsr_q        <= LFSR_SEED;
            mono_q        <= '0;
            left_q        <= '0;
            right_q       <= '0;
        end else begin
            sel_prev_q    <= sel_prev_d;
            stereo_prev_q <= stereo_prev_d;
            ready_q       <= ready_d;
            busy_q        <= busy_d;
            latch_ch_q    <= latch_ch_d;
            latch_type_q  <= latch_type_d;
            pan_q         <= pan_d;
            div_q         <= div_d;
            nctrl_q       <= nctrl_d;
            natt_q        <= natt_d;
            ncnt_q        <= ncnt_d;
            nsq_q         <= nsq_d;
            nsrc_prev_q   <= nsrc_prev_d;
            lfsr_q        <= lfsr_d;
            mono_q        <= mono_d;
            left_q        <= left_d;
            right_q       <= right_d;
        end
    end

    assign READY  = ready_q;
    assign AOUT   = mono_q;
    assign AOUT_L = left_q;
    assign AOUT_R = right_q;

endmodule
`default_nettype wire
